intr_take: RTL and testbench

//  CPU-side consumer of the interrupt controller. Samples the controller's level

---
 rtl/intr_pkg.sv | 22 ++
 rtl/intr_prio_enc.sv | 20 ++
 rtl/intr_take.sv | 138 +++++++++++++
 tb/tb_intr_take.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/intr_pkg.sv
// Shared types and constants for the CPU-side interrupt take logic.
package intr_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      SYNC    = 3'd1,
      READ    = 3'd2,
      DECIDE  = 3'd3,
      TAKE    = 3'd4,
      HANDLER = 3'd5
   } intr_state_e;

   localparam logic [3:0] PEND_ADDR_DEF = 4'h0;

   // Source indices as wired on the interrupt controller; bit 0 wins
   localparam int unsigned SRC_UART  = 0;
   localparam int unsigned SRC_CLOCK = 1;
   localparam int unsigned SRC_TIMER = 2;
   localparam int unsigned SRC_SWI   = 3;
   localparam int unsigned SRC_SD    = 4;

endpackage

// File: rtl/intr_prio_enc.sv
// Lowest-set-bit priority encoder: bit 0 has the highest priority.
module intr_prio_enc #(
   parameter int N  = 5,
   parameter int IW = 3
) (
   input  logic [N-1:0]  vec_i,
   output logic [IW-1:0] idx_o,
   output logic          any_o
);

   always_comb begin
      idx_o = '0;
      any_o = |vec_i;
      // Walk downward so the lowest set bit is the last one written
      for (int i = N - 1; i >= 0; i--) begin
         if (vec_i[i]) idx_o = IW'(i);
      end
   end

endmodule

// File: rtl/intr_take.sv
// Waits for an instruction boundary, reads the pending register over io,
// and requests a trap to the vector of the highest-priority pending source.
module intr_take
   import intr_pkg::*;
#(
   parameter int          NSRC       = 5,
   parameter logic [3:0]  PEND_ADDR  = PEND_ADDR_DEF,
   parameter logic [15:0] VEC_BASE   = 16'h0010,
   parameter int          VEC_SHIFT  = 2,
   parameter int          IO_TIMEOUT = 15
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        interrupt,
   input  logic        insn_boundary,
   input  logic        ie_write,
   input  logic        ie_wdata,
   input  logic        rti,
   input  logic        trap_ack,
   output logic        io_req,
   output logic [3:0]  io_addr,
   input  logic [15:0] io_rdata,
   input  logic        io_ack,
   output logic        take,
   output logic [2:0]  cause,
   output logic [15:0] vector,
   output logic        ie,
   output logic        in_handler,
   output logic        io_err
);

   localparam int TW = $clog2(IO_TIMEOUT + 1);
   localparam logic [TW-1:0] TMO_MAX = TW'(IO_TIMEOUT);

   intr_state_e     state_q, state_d;
   logic [TW-1:0]   tmo_q, tmo_d;
   logic [NSRC-1:0] pend_q, pend_d;
   logic [2:0]      cause_q, cause_d;
   logic            ie_q, ie_d;
   logic            prev_ie_q, prev_ie_d;
   logic            io_err_q, io_err_d;

   logic [2:0]      enc_idx;
   logic            enc_any;
   logic            unused_rdata;

   assign unused_rdata = ^io_rdata;

   intr_prio_enc #(.N(NSRC), .IW(3)) u_enc (
      .vec_i (pend_q),
      .idx_o (enc_idx),
      .any_o (enc_any)
   );

   always_comb begin
      state_d   = state_q;
      tmo_d     = tmo_q;
      pend_d    = pend_q;
      cause_d   = cause_q;
      io_err_d  = 1'b0;
      ie_d      = ie_q;
      prev_ie_d = prev_ie_q;

      case (state_q)
         IDLE:    if (interrupt && ie_q) state_d = SYNC;
         SYNC: begin
            if (!interrupt || !ie_q) begin
               state_d = IDLE;
            end else if (insn_boundary) begin
               state_d = READ;
               tmo_d   = '0;
            end
         end
         READ: begin
            // An ack on the last allowed cycle still counts
            if (io_ack) begin
               pend_d  = io_rdata[NSRC-1:0];
               state_d = DECIDE;
            end else if (tmo_q == TMO_MAX) begin
               io_err_d = 1'b1;
               state_d  = IDLE;
            end else begin
               tmo_d = tmo_q + 1'b1;
            end
         end
         DECIDE: begin
            if (enc_any) begin
               cause_d = enc_idx;
               state_d = TAKE;
            end else begin
               state_d = IDLE;
            end
         end
         TAKE:    if (trap_ack) state_d = HANDLER;
         HANDLER: if (rti) state_d = IDLE;
         default: state_d = IDLE;
      endcase

      if (rti && state_q == HANDLER) begin
         ie_d = prev_ie_q;
      end else if (trap_ack && state_q == TAKE) begin
         prev_ie_d = ie_q;
         ie_d      = 1'b0;
      end else if (ie_write) begin
         ie_d = ie_wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         tmo_q     <= '0;
         pend_q    <= '0;
         cause_q   <= '0;
         ie_q      <= 1'b0;
         prev_ie_q <= 1'b0;
         io_err_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         tmo_q     <= tmo_d;
         pend_q    <= pend_d;
         cause_q   <= cause_d;
         ie_q      <= ie_d;
         prev_ie_q <= prev_ie_d;
         io_err_q  <= io_err_d;
      end
   end

   assign io_req     = (state_q == READ);
   assign io_addr    = io_req ? PEND_ADDR : 4'h0;
   assign take       = (state_q == TAKE);
   assign in_handler = (state_q == HANDLER);
   assign cause      = cause_q;
   assign vector     = VEC_BASE + (16'(cause_q) << VEC_SHIFT);
   assign ie         = ie_q;
   assign io_err     = io_err_q;

endmodule

// File: tb/tb_intr_take.sv
// Self-checking bench for intr_take: vector table with scoreboard, plus corner sequences.
module tb_intr_take;

   logic        clk = 1'b0;
   logic        reset, interrupt, insn_boundary, ie_write, ie_wdata, rti, trap_ack;
   logic        io_req, io_ack, take, ie, in_handler, io_err;
   logic [3:0]  io_addr;
   logic [15:0] io_rdata, vector;
   logic [2:0]  cause;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic        take;
      logic [2:0]  cause;
      logic [15:0] vector;
   } exp_t;

   typedef struct {
      logic [15:0] rdata;
      exp_t        e;
   } vec_t;

   exp_t sb[$];
   vec_t tbl[8];

   intr_take dut (
      .clk(clk), .reset(reset), .interrupt(interrupt), .insn_boundary(insn_boundary),
      .ie_write(ie_write), .ie_wdata(ie_wdata), .rti(rti), .trap_ack(trap_ack),
      .io_req(io_req), .io_addr(io_addr), .io_rdata(io_rdata), .io_ack(io_ack),
      .take(take), .cause(cause), .vector(vector), .ie(ie),
      .in_handler(in_handler), .io_err(io_err)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic set_ie(input logic v);
      ie_write = 1'b1; ie_wdata = v;
      tick();
      ie_write = 1'b0;
   endtask

   // From IDLE with ie=1: drive a request whose ack arrives on the first READ cycle
   task automatic drive_to_decide_plus1(input logic [15:0] rd);
      interrupt = 1'b1; insn_boundary = 1'b1; io_ack = 1'b1; io_rdata = rd;
      repeat (4) tick();
      interrupt = 1'b0; io_ack = 1'b0;
   endtask

   task automatic finish_handler();
      trap_ack = 1'b1; tick(); trap_ack = 1'b0;
      rti = 1'b1; tick(); rti = 1'b0;
   endtask

   initial begin
      exp_t e;
      int   req_cnt, err_cnt, take_cnt;
      logic seen;

      reset = 1'b1; interrupt = 1'b0; insn_boundary = 1'b0; ie_write = 1'b0;
      ie_wdata = 1'b0; rti = 1'b0; trap_ack = 1'b0; io_rdata = '0; io_ack = 1'b0;

      tbl[0] = '{16'h0004, '{1'b1, 3'd2, 16'h0018}};
      tbl[1] = '{16'h0018, '{1'b1, 3'd3, 16'h001C}};
      tbl[2] = '{16'h0001, '{1'b1, 3'd0, 16'h0010}};
      tbl[3] = '{16'h0010, '{1'b1, 3'd4, 16'h0020}};
      tbl[4] = '{16'h0000, '{1'b0, 3'd0, 16'h0000}};
      tbl[5] = '{16'hFFE0, '{1'b0, 3'd0, 16'h0000}};
      tbl[6] = '{16'hFFFF, '{1'b1, 3'd0, 16'h0010}};
      tbl[7] = '{16'h0006, '{1'b1, 3'd1, 16'h0014}};

      repeat (2) tick();
      reset = 1'b0;
      chk("rst_io_req", 16'(io_req), 16'h0);
      chk("rst_take", 16'(take), 16'h0);
      chk("rst_ie", 16'(ie), 16'h0);
      chk("rst_in_handler", 16'(in_handler), 16'h0);
      chk("rst_io_err", 16'(io_err), 16'h0);
      chk("rst_cause", 16'(cause), 16'h0);
      chk("rst_vector", vector, 16'h0010);

      set_ie(1'b1);
      chk("ie_write", 16'(ie), 16'h1);

      // Minimum latency: take appears on the 4th edge, not before
      interrupt = 1'b1; insn_boundary = 1'b1; io_ack = 1'b1; io_rdata = 16'h0004;
      tick(); chk("lat_e1_take", 16'(take), 16'h0);
      tick(); chk("lat_e2_io_req", 16'(io_req), 16'h1);
      chk("lat_e2_io_addr", 16'(io_addr), 16'h0);
      tick(); chk("lat_e3_take", 16'(take), 16'h0);
      chk("lat_e3_io_req", 16'(io_req), 16'h0);
      tick(); chk("lat_e4_take", 16'(take), 16'h1);
      chk("lat_cause", 16'(cause), 16'h2);
      chk("lat_vector", vector, 16'h0018);
      io_ack = 1'b0;
      interrupt = 1'b0;
      tick(); chk("take_held", 16'(take), 16'h1);
      trap_ack = 1'b1; tick(); trap_ack = 1'b0;
      chk("trap_ie", 16'(ie), 16'h0);
      chk("trap_in_handler", 16'(in_handler), 16'h1);
      chk("trap_take", 16'(take), 16'h0);
      interrupt = 1'b1;
      tick(); chk("no_nest_io_req", 16'(io_req), 16'h0);
      chk("handler_cause", 16'(cause), 16'h2);
      // Re-entry: line still high, rti returns to IDLE then SYNC, READ
      rti = 1'b1; tick(); rti = 1'b0;
      chk("rti_ie", 16'(ie), 16'h1);
      chk("rti_in_handler", 16'(in_handler), 16'h0);
      tick(); chk("reent_sync_io_req", 16'(io_req), 16'h0);
      tick(); chk("reent_read_io_req", 16'(io_req), 16'h1);
      io_ack = 1'b1; io_rdata = 16'h0000; interrupt = 1'b0;
      repeat (2) tick();
      io_ack = 1'b0;
      chk("reent_spur_take", 16'(take), 16'h0);
      tick();

      // Table: expectation queued at drive time, popped when outcome is due
      for (int i = 0; i < 8; i++) begin
         sb.push_back(tbl[i].e);
         drive_to_decide_plus1(tbl[i].rdata);
         e = sb.pop_front();
         chk($sformatf("tbl%0d_take", i), 16'(take), 16'(e.take));
         if (e.take) begin
            chk($sformatf("tbl%0d_cause", i), 16'(cause), 16'(e.cause));
            chk($sformatf("tbl%0d_vector", i), vector, e.vector);
            finish_handler();
         end else begin
            chk($sformatf("tbl%0d_in_handler", i), 16'(in_handler), 16'h0);
         end
         chk($sformatf("tbl%0d_ie", i), 16'(ie), 16'h1);
         tick();
      end

      // ie=0: no io_req ever
      set_ie(1'b0);
      interrupt = 1'b1; insn_boundary = 1'b1; io_ack = 1'b1; io_rdata = 16'h0001;
      seen = 1'b0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (io_req) seen = 1'b1;
      end
      chk("ie0_no_io_req", 16'(seen), 16'h0);
      interrupt = 1'b0; io_ack = 1'b0;
      set_ie(1'b1);

      // Interrupt drops in SYNC before the boundary
      interrupt = 1'b1; insn_boundary = 1'b0;
      tick();
      interrupt = 1'b0; insn_boundary = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (io_req) seen = 1'b1;
      end
      chk("sync_drop_no_io_req", 16'(seen), 16'h0);

      // Timeout: io_req held 16 cycles, one io_err pulse, no take
      interrupt = 1'b1; insn_boundary = 1'b1; io_ack = 1'b0;
      repeat (2) tick();
      interrupt = 1'b0;
      req_cnt = 0; err_cnt = 0; take_cnt = 0;
      for (int i = 0; i < 30; i++) begin
         if (io_req) req_cnt++;
         if (io_err) err_cnt++;
         if (take) take_cnt++;
         tick();
      end
      chk("tmo_req_cycles", 16'(req_cnt), 16'd16);
      chk("tmo_err_pulses", 16'(err_cnt), 16'd1);
      chk("tmo_take", 16'(take_cnt), 16'd0);
      chk("tmo_ie", 16'(ie), 16'h1);

      // Ack on the final timeout cycle wins
      interrupt = 1'b1; insn_boundary = 1'b1; io_ack = 1'b0;
      repeat (2) tick();
      interrupt = 1'b0;
      repeat (15) tick();
      chk("lastcyc_io_req", 16'(io_req), 16'h1);
      io_ack = 1'b1; io_rdata = 16'h0002;
      tick(); io_ack = 1'b0;
      chk("lastcyc_io_err", 16'(io_err), 16'h0);
      chk("lastcyc_io_req_off", 16'(io_req), 16'h0);
      tick();
      chk("lastcyc_take", 16'(take), 16'h1);
      chk("lastcyc_cause", 16'(cause), 16'h1);
      finish_handler();
      tick();

      // Stray pulses outside their states leave ie alone
      trap_ack = 1'b1; tick(); trap_ack = 1'b0;
      chk("stray_trap_ie", 16'(ie), 16'h1);
      set_ie(1'b0);
      rti = 1'b1; tick(); rti = 1'b0;
      chk("stray_rti_ie", 16'(ie), 16'h0);
      set_ie(1'b1);

      // Reset in READ
      interrupt = 1'b1; insn_boundary = 1'b1; io_ack = 1'b0;
      repeat (2) tick();
      chk("rstread_pre_io_req", 16'(io_req), 16'h1);
      reset = 1'b1; tick(); reset = 1'b0; interrupt = 1'b0;
      chk("rstread_io_req", 16'(io_req), 16'h0);
      chk("rstread_ie", 16'(ie), 16'h0);
      set_ie(1'b1);

      // Reset in TAKE
      drive_to_decide_plus1(16'h0008);
      chk("rsttake_pre_take", 16'(take), 16'h1);
      reset = 1'b1; tick(); reset = 1'b0;
      chk("rsttake_take", 16'(take), 16'h0);
      chk("rsttake_ie", 16'(ie), 16'h0);
      chk("rsttake_cause", 16'(cause), 16'h0);
      set_ie(1'b1);

      // rti beats a same-cycle ie_write in HANDLER
      drive_to_decide_plus1(16'h0010);
      trap_ack = 1'b1; tick(); trap_ack = 1'b0;
      chk("prio_handler_ie", 16'(ie), 16'h0);
      rti = 1'b1; ie_write = 1'b1; ie_wdata = 1'b0;
      tick();
      rti = 1'b0; ie_write = 1'b0;
      chk("prio_rti_ie", 16'(ie), 16'h1);
      chk("prio_in_handler", 16'(in_handler), 16'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
